// File: rtl/traffic_light_controller_pkg.sv
// Shared types and lamp encodings for the highway/farm-road intersection controller.
package traffic_light_controller_pkg;

    typedef enum logic [1:0] {
        ST_HG = 2'd0,
        ST_HY = 2'd1,
        ST_FG = 2'd2,
        ST_FY = 2'd3
    } state_t;

    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_RED    = 3'b100;

endpackage

// File: rtl/traffic_light_controller_sync_2ff.sv
// Two-flop synchronizer for a slow asynchronous level input; both flops reset to 0.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/traffic_light_controller.sv
// Highway/farm-road intersection controller: highway green by default, farm phase on request.
// States: HG highway green | HY highway yellow | FG farm green | FY farm yellow
module traffic_light_controller
    import traffic_light_controller_pkg::*;
#(
    parameter int HWY_MIN_GREEN  = 2_500_000,
    parameter int YELLOW         = 1_000_000,
    parameter int FARM_MAX_GREEN = 2_500_000,
    parameter int CNT_W          = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sensor,
    output logic [2:0] highway_light,
    output logic [2:0] farm_light
);

    localparam logic [CNT_W-1:0] HG_LAST  = CNT_W'(HWY_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] FG_LAST  = CNT_W'(FARM_MAX_GREEN - 1);

    logic             w_sensor_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_hwy_light;
    logic [2:0]       r_farm_light;

    sync_2ff u_sync (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (sensor),
        .o_q   (w_sensor_s)
    );

    // Lamp registers are loaded on the same edge as the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_HG;
            r_cnt        <= '0;
            r_hwy_light  <= LAMP_GREEN;
            r_farm_light <= LAMP_RED;
        end else begin
            case (r_state)
                ST_HG: begin
                    if (r_cnt == HG_LAST && w_sensor_s) begin
                        r_state     <= ST_HY;
                        r_cnt       <= '0;
                        r_hwy_light <= LAMP_YELLOW;
                    end else if (r_cnt != HG_LAST) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_HY: begin
                    if (r_cnt == YEL_LAST) begin
                        r_state      <= ST_FG;
                        r_cnt        <= '0;
                        r_hwy_light  <= LAMP_RED;
                        r_farm_light <= LAMP_GREEN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_FG: begin
                    if (!w_sensor_s || r_cnt == FG_LAST) begin
                        r_state      <= ST_FY;
                        r_cnt        <= '0;
                        r_farm_light <= LAMP_YELLOW;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_FY: begin
                    if (r_cnt == YEL_LAST) begin
                        r_state      <= ST_HG;
                        r_cnt        <= '0;
                        r_hwy_light  <= LAMP_GREEN;
                        r_farm_light <= LAMP_RED;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_HG;
                    r_cnt        <= '0;
                    r_hwy_light  <= LAMP_GREEN;
                    r_farm_light <= LAMP_RED;
                end
            endcase
        end
    end

    assign highway_light = r_hwy_light;
    assign farm_light    = r_farm_light;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Segment-table bench for traffic_light_controller with a per-cycle expected-lamp scoreboard.
module tb_traffic_light_controller;
    import traffic_light_controller_pkg::*;

    localparam int HMIN = 10;
    localparam int YEL  = 3;
    localparam int FMAX = 8;

    localparam logic [2:0] G = LAMP_GREEN;
    localparam logic [2:0] Y = LAMP_YELLOW;
    localparam logic [2:0] R = LAMP_RED;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sensor = 1'b0;
    logic [2:0] highway_light;
    logic [2:0] farm_light;

    traffic_light_controller #(
        .HWY_MIN_GREEN  (HMIN),
        .YELLOW         (YEL),
        .FARM_MAX_GREEN (FMAX),
        .CNT_W          (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sensor        (sensor),
        .highway_light (highway_light),
        .farm_light    (farm_light)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_first;
        logic       sens;
        int         cycles;
        logic [2:0] hwy;
        logic [2:0] farm;
        string      name;
    } seg_t;

    typedef struct {
        logic [2:0] hwy;
        logic [2:0] farm;
        string      name;
    } exp_t;

    seg_t segs[$];
    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   failures = 0;

    // Scoreboard and lamp invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            checks++;
            if (highway_light !== cur.hwy || farm_light !== cur.farm) begin
                failures++;
                $display("FAIL %s: got hwy=%b farm=%b, expected hwy=%b farm=%b",
                         cur.name, highway_light, farm_light, cur.hwy, cur.farm);
            end
        end
        checks++;
        if (!($onehot(highway_light) && $onehot(farm_light) &&
              (highway_light == R || farm_light == R))) begin
            failures++;
            $display("FAIL invariant: got hwy=%b farm=%b, expected one-hot with at least one red",
                     highway_light, farm_light);
        end
    end

    function automatic void add(input logic rf, input logic s, input int n,
                                input logic [2:0] h, input logic [2:0] f, input string nm);
        seg_t e;
        e.rst_first = rf;
        e.sens      = s;
        e.cycles    = n;
        e.hwy       = h;
        e.farm      = f;
        e.name      = nm;
        segs.push_back(e);
    endfunction

    task automatic push_exp(input logic [2:0] h, input logic [2:0] f, input string nm);
        exp_t e;
        e.hwy  = h;
        e.farm = f;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic do_reset(input int n);
        rst    = 1'b1;
        sensor = 1'b0;
        for (int i = 0; i < n; i++) begin
            push_exp(G, R, "reset_hold");
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    task automatic apply(input logic s, input int n, input logic [2:0] h,
                         input logic [2:0] f, input string nm);
        for (int i = 0; i < n; i++) begin
            sensor = s;
            push_exp(h, f, nm);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // No request
        add(1, 0, 100, G, R, "a_no_req");
        // Sensor held from cycle 2: full cycle and back to highway
        add(1, 0, 2,  G, R, "b_hg_pre");
        add(0, 1, 8,  G, R, "b_hg_min");
        add(0, 1, 3,  Y, R, "b_hy");
        add(0, 1, 8,  R, G, "b_fg_max");
        add(0, 1, 3,  R, Y, "b_fy");
        add(0, 1, 10, G, R, "b_hg_again");
        add(0, 1, 1,  Y, R, "b_hy2");
        // Early farm exit, then a new request must wait out the highway minimum
        add(1, 0, 2,  G, R, "c_hg_pre");
        add(0, 1, 8,  G, R, "c_hg_min");
        add(0, 1, 3,  Y, R, "c_hy");
        add(0, 1, 4,  R, G, "c_fg");
        add(0, 0, 3,  R, G, "c_fg_drop");
        add(0, 0, 3,  R, Y, "c_fy");
        add(0, 1, 10, G, R, "c_hg_min_after");
        add(0, 1, 3,  Y, R, "c_hy2");
        // Late request after minimum has long expired
        add(1, 0, 40, G, R, "d_idle");
        add(0, 1, 3,  G, R, "d_req_latency");
        add(0, 1, 3,  Y, R, "d_hy");
        // sensor_s falls on the cycle FG reaches its maximum; HG then holds without request
        add(1, 0, 2,  G, R, "e_hg_pre");
        add(0, 1, 8,  G, R, "e_hg_min");
        add(0, 1, 3,  Y, R, "e_hy");
        add(0, 1, 5,  R, G, "e_fg");
        add(0, 0, 3,  R, G, "e_fg_edge");
        add(0, 0, 3,  R, Y, "e_fy");
        add(0, 0, 20, G, R, "e_hg_hold");
        add(0, 1, 3,  G, R, "e_req");
        add(0, 1, 3,  Y, R, "e_hy2");

        @(posedge clk);
        #1;
        foreach (segs[k]) begin
            if (segs[k].rst_first) do_reset(5);
            apply(segs[k].sens, segs[k].cycles, segs[k].hwy, segs[k].farm, segs[k].name);
        end

        // Reset asserted mid-FG takes effect before the next clock edge
        do_reset(2);
        apply(0, 2, G, R, "f_hg_pre");
        apply(1, 8, G, R, "f_hg_min");
        apply(1, 3, Y, R, "f_hy");
        apply(1, 3, R, G, "f_fg");
        rst = 1'b1;
        #1;
        checks++;
        if (highway_light !== G || farm_light !== R) begin
            failures++;
            $display("FAIL f_async_reset: got hwy=%b farm=%b, expected hwy=%b farm=%b",
                     highway_light, farm_light, G, R);
        end
        push_exp(G, R, "f_reset_hold");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            push_exp(G, R, "f_reset_hold");
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(1, 10, G, R, "f_hg_after_rst");
        apply(1, 3,  Y, R, "f_hy_after_rst");

        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
